ufm_streamer: RTL
=================

# ufm_streamer

Parametrised UFM region streamer that replaces the hand-built counter, break and page-buffer glue in demo tops. It drives `ufm_reader` page by page, holds each 16-byte page in an internal buffer, and presents the bytes of a configurable byte range on a valid/ready byte stream, for example to `uart`. It supports one-shot and looping passes, a programmable pause between passes, unaligned start and end offsets, abort, and a pass counter.

## Interface

**Parameters**
- `START_OFFSET`, default 32672 (2042*16): first UFM byte address (15-bit), any alignment.
- `SIZE`, default 64: bytes per pass, range 1..(32768-START_OFFSET).
- `LOOP`, default 1: 1 restarts the pass after the pause; 0 returns to IDLE after one pass.
- `AUTOSTART`, default 1: 1 leaves reset directly into FETCH; 0 waits in IDLE for `go`.
- `PAUSE_CYCLES`, default 12090000: idle clocks between looped passes; 0 means no pause.

**Ports**
- `clk`, in, 1: sole clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `go`, in, 1: starts a pass from IDLE; ignored in all other states.
- `abort`, in, 1: forces IDLE from any state.
- `rd_start`, out, 1: one-cycle page-read strobe to `ufm_reader.start`.
- `rd_addr`, out, 11: page number to `ufm_reader.addr`.
- `rd_data`, in, 8: byte from `ufm_reader.data`.
- `rd_stb`, in, 1: byte-valid from `ufm_reader.data_stb`.
- `rd_ready`, in, 1: reader idle, from `ufm_reader.ready`.
- `out_data`, out, 8: stream byte.
- `out_valid`, out, 1: stream byte valid.
- `out_ready`, in, 1: sink accepts.
- `out_last`, out, 1: current byte is the final byte of the pass.
- `busy`, out, 1: high in any state other than IDLE.
- `pass_cnt`, out, 16: completed passes; wraps from 16'hFFFF to 0.

## Operation

**State machine.** States are IDLE, FETCH, WAIT_PAGE, SEND and PAUSE.

**Registers.** `cur_addr` (15 bits), `buf[0:15]` (8 bits each), `cap_idx` (5 bits), `pause_cnt` (32 bits).

**State behaviour**
- **IDLE**
  - On `go`, load `cur_addr` = START_OFFSET and go to FETCH.
- **FETCH**
  - On the first cycle with `rd_ready`=1: pulse `rd_start`, set `rd_addr` = `cur_addr[14:4]`, clear `cap_idx`, go to WAIT_PAGE.
- **WAIT_PAGE**
  - Each `rd_stb` writes `rd_data` to `buf[cap_idx]` and increments `cap_idx`.
  - When `cap_idx` reaches 16, go to SEND. Further `rd_stb` is ignored.
- **SEND**
  - `out_valid`=1 and `out_data` = `buf[cur_addr[3:0]]`.
  - On `out_valid & out_ready`:
    - If `cur_addr` == START_OFFSET+SIZE-1, the pass is done: increment `pass_cnt`. Then:
      - LOOP=0: go to IDLE.
      - LOOP=1 and PAUSE_CYCLES>0: go to PAUSE.
      - LOOP=1 and PAUSE_CYCLES=0: reload `cur_addr` and go to FETCH.
    - Otherwise, if `cur_addr[3:0]`==15: increment `cur_addr` and go to FETCH.
    - Otherwise: increment `cur_addr` and stay in SEND.
- **PAUSE**
  - Count PAUSE_CYCLES clocks, then reload `cur_addr` = START_OFFSET and go to FETCH.

**Other rules**
- `out_last` = SEND and (`cur_addr` == START_OFFSET+SIZE-1).
- Unaligned start: the whole first page is captured; bytes below START_OFFSET[3:0] are never presented.
- Unaligned end: bytes after the end address are captured and discarded.
- `abort` overrides every other transition. The next state is IDLE, `out_valid` drops next cycle, and `pass_cnt` is unchanged.
- In-flight reader bytes after an abort are ignored. A new fetch waits for `rd_ready`.
- `rd_stb` is ignored outside WAIT_PAGE.
- `cur_addr` arithmetic is 15-bit; END = START_OFFSET+SIZE-1 is computed at elaboration.
- The elaboration check fails if the range exceeds 15 bits.

## Timing

**Reset values**
- State: FETCH if AUTOSTART=1, else IDLE.
- `rd_start`=0, `rd_addr`=START_OFFSET[14:4].
- `out_valid`=0, `out_last`=0, `out_data`=0 (buffer cleared).
- `busy`=AUTOSTART, `pass_cnt`=0.

**Latencies**
- `go` sampled at edge N: `busy`=1 after N, and `rd_start` can pulse no earlier than after N+1.
- `rd_start` is high for exactly 1 cycle per page.
- 16th `rd_stb` sampled at edge N: `out_valid`=1 after N.
- Throughput within a page is 1 byte/clk while `out_ready`=1.
- Data is stable while `out_valid & !out_ready`.
- Page crossing: `out_valid` drops the cycle after the accept of byte 15 of the page.
- Pause: the last-byte accept is at edge N, and `rd_start` is no earlier than edge N+PAUSE_CYCLES+1.

**Simultaneous events**
- `abort` together with `out_ready` on the last byte: abort wins, there is no `pass_cnt` increment, and the byte counts as not accepted.
- `go` together with `abort` in IDLE: stay in IDLE.
- Asynchronous `rst` mid-page: all outputs take their reset values immediately.

## Test plan

1. **Default parameters, model reader with 1-clk `rd_stb` spacing.** Expect exactly 64 bytes from page 2042 (4 pages) in order, `out_last` on the 64th byte, then `pass_cnt`=1 and `busy`=1 in PAUSE.
2. **LOOP=0, AUTOSTART=0, START_OFFSET=32675, SIZE=20, pulse `go`.**
   - `rd_addr` 2042 then 2043.
   - Bytes at 32675..32694 delivered, with first byte = page byte 3.
   - Back to IDLE, `busy`=0.
   - A second `go` repeats the pass and `pass_cnt`=2.
3. **Backpressure: `out_ready` random 30% duty.** Expect no byte dropped or duplicated, and `out_data` held constant while stalled.
4. **Abort during WAIT_PAGE after 7 `rd_stb`, remaining 9 strobes still arriving.**
   - IDLE next cycle, `out_valid`=0.
   - A later `go` fetches cleanly from START_OFFSET once `rd_ready`=1.
5. **PAUSE_CYCLES=5, SIZE=1.** Check the gap from last accept to the next `rd_start` is ≥6 clk. Then with PAUSE_CYCLES=0, the next FETCH follows immediately.
6. **Assert `rst` asynchronously mid-SEND.** All outputs take their reset values without waiting for a clock edge, and streaming restarts from START_OFFSET after release.

Source files
------------

// File: rtl/ufm_streamer_if.sv
// Reader-side and stream-side signals of ufm_streamer, bundled for port lists.
//
// Handshakes:
//   Reader: rd_start is a one-cycle request for page rd_addr. It is only
//   issued while rd_ready is high. The reader then returns 16 bytes, each one
//   qualified by rd_stb for a single cycle.
//   Stream: a byte moves on a rising edge where out_valid and out_ready are
//   both high. While out_valid is high and out_ready is low, out_data and
//   out_last hold their values. out_valid never depends combinationally on
//   out_ready.
interface ufm_streamer_if;
  logic        rd_start;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic        rd_stb;
  logic        rd_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (
    output rd_start, rd_addr, out_data, out_valid, out_last,
    input  rd_data, rd_stb, rd_ready, out_ready
  );

  modport slave (
    input  rd_start, rd_addr, out_data, out_valid, out_last,
    output rd_data, rd_stb, rd_ready, out_ready
  );
endinterface

// File: rtl/ufm_streamer.sv
// UFM region streamer. It fetches 16-byte pages from ufm_reader into a local
// buffer and streams the bytes of [START_OFFSET, START_OFFSET+SIZE-1] out,
// one per accepted handshake. It supports one-shot or looping passes, a pause
// between passes, and abort.
module ufm_streamer #(
  parameter int          START_OFFSET = 32672,
  parameter int          SIZE         = 64,
  parameter int          LOOP         = 1,
  parameter int          AUTOSTART    = 1,
  parameter int unsigned PAUSE_CYCLES = 12090000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic                  abort,
  ufm_streamer_if.master        bus,
  output logic                  busy,
  output logic [15:0]           pass_cnt,
  output logic [2:0]            state_dbg_o
);

  if (SIZE < 1 || START_OFFSET < 0 || START_OFFSET + SIZE > 32768) begin : g_bad_range
    $error("ufm_streamer: byte range exceeds the 15-bit UFM address space");
  end

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_PAGE = 3'd2,
    ST_SEND      = 3'd3,
    ST_PAUSE     = 3'd4
  } state_t;

  localparam logic [14:0] START_A    = 15'(START_OFFSET);
  localparam logic [14:0] END_A      = 15'(START_OFFSET + SIZE - 1);
  localparam logic [31:0] PAUSE_LAST = (PAUSE_CYCLES > 0) ? 32'(PAUSE_CYCLES - 1) : 32'd0;
  localparam state_t      RST_STATE  = (AUTOSTART != 0) ? ST_FETCH : ST_IDLE;

  state_t      state_q, state_d;
  logic [14:0] cur_addr_q, cur_addr_d;
  logic [7:0]  buf_q [16];
  logic [7:0]  buf_d [16];
  logic [4:0]  cap_idx_q, cap_idx_d;
  logic [31:0] pause_cnt_q, pause_cnt_d;
  logic        rd_start_q, rd_start_d;
  logic [10:0] rd_addr_q, rd_addr_d;
  logic [15:0] pass_cnt_q, pass_cnt_d;

  // Next-state logic for the whole streamer; abort is applied last so that it overrides every transition.
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    buf_d       = buf_q;
    cap_idx_d   = cap_idx_q;
    pause_cnt_d = pause_cnt_q;
    rd_start_d  = 1'b0;
    rd_addr_d   = rd_addr_q;
    pass_cnt_d  = pass_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          cur_addr_d = START_A;
          state_d    = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // Waiting on rd_ready also keeps a new request from overlapping
        // bytes still arriving from an aborted page.
        if (bus.rd_ready) begin
          rd_start_d = 1'b1;
          rd_addr_d  = cur_addr_q[14:4];
          cap_idx_d  = 5'd0;
          state_d    = ST_WAIT_PAGE;
        end
      end

      ST_WAIT_PAGE: begin
        if (bus.rd_stb) begin
          buf_d[cap_idx_q[3:0]] = bus.rd_data;
          cap_idx_d             = cap_idx_q + 5'd1;
          if (cap_idx_q == 5'd15) begin
            state_d = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        if (bus.out_ready) begin
          if (cur_addr_q == END_A) begin
            pass_cnt_d = pass_cnt_q + 16'd1;
            if (LOOP == 0) begin
              state_d = ST_IDLE;
            end else if (PAUSE_CYCLES > 0) begin
              pause_cnt_d = 32'd0;
              state_d     = ST_PAUSE;
            end else begin
              cur_addr_d = START_A;
              state_d    = ST_FETCH;
            end
          end else begin
            cur_addr_d = cur_addr_q + 15'd1;
            if (cur_addr_q[3:0] == 4'hF) begin
              state_d = ST_FETCH;
            end
          end
        end
      end

      ST_PAUSE: begin
        if (pause_cnt_q == PAUSE_LAST) begin
          cur_addr_d = START_A;
          state_d    = ST_FETCH;
        end else begin
          pause_cnt_d = pause_cnt_q + 32'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // If abort arrives with the last byte, that byte counts as not accepted.
    if (abort) begin
      state_d    = ST_IDLE;
      cur_addr_d = cur_addr_q;
      pass_cnt_d = pass_cnt_q;
      rd_start_d = 1'b0;
      rd_addr_d  = rd_addr_q;
    end
  end

  // State, buffer and output registers; asynchronous reset restores the power-up view.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RST_STATE;
      cur_addr_q  <= START_A;
      for (int i = 0; i < 16; i++) buf_q[i] <= 8'h00;
      cap_idx_q   <= 5'd0;
      pause_cnt_q <= 32'd0;
      rd_start_q  <= 1'b0;
      rd_addr_q   <= START_A[14:4];
      pass_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      for (int i = 0; i < 16; i++) buf_q[i] <= buf_d[i];
      cap_idx_q   <= cap_idx_d;
      pause_cnt_q <= pause_cnt_d;
      rd_start_q  <= rd_start_d;
      rd_addr_q   <= rd_addr_d;
      pass_cnt_q  <= pass_cnt_d;
    end
  end

  assign bus.rd_start  = rd_start_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.out_valid = (state_q == ST_SEND);
  assign bus.out_data  = buf_q[cur_addr_q[3:0]];
  assign bus.out_last  = (state_q == ST_SEND) && (cur_addr_q == END_A);
  assign busy          = (state_q != ST_IDLE);
  assign pass_cnt      = pass_cnt_q;
  assign state_dbg_o   = state_q;

endmodule
